dbg_core_access: RTL

Debug-side master for the core's debug port. It accepts debug-module requests over a valid/ready request channel and answers on a valid/ready response channel. It sequences the core's `jtag_halt`, `jtag_reset`, `reg_wen`, `reg_addr` and `reg_w_data` inputs, and samples `reg_r_data`. It sits between the JTAG/DMI transport and the core top, and is the initiating end of the core's GPR/halt/reset debug interface.

---
 rtl/dbg_core_access.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dbg_core_access.sv
// Debug master for the core's GPR/halt/reset port; one request in flight, latency 1..(1+N) cycles per op.
// Backpressure: RESP holds data/err until dmi_resp_ready, and no request is accepted outside IDLE.
module dbg_core_access #(
   parameter int unsigned HALT_SETTLE  = 2,
   parameter int unsigned RESET_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        dmi_req_valid,
   output logic        dmi_req_ready,
   input  logic [1:0]  dmi_req_op,
   input  logic [4:0]  dmi_req_addr,
   input  logic [31:0] dmi_req_data,
   output logic        dmi_resp_valid,
   input  logic        dmi_resp_ready,
   output logic [31:0] dmi_resp_data,
   output logic        dmi_resp_err,
   output logic        jtag_halt,
   output logic        jtag_reset,
   output logic        reg_wen,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_w_data,
   input  logic [31:0] reg_r_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ACCESS,
      S_RST,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_STATUS = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_WRITE  = 2'b10;

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic [1:0]  op_q, op_d;
   logic        halt_req, halt_req_d;
   logic        halted, halted_d;
   logic        reset_active, reset_active_d;
   logic        jreset_q, jreset_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  ctrl;
   logic [31:0] status;

   assign status = {29'b0, reset_active, halted, halt_req};
   assign ctrl   = dmi_req_data[2:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         cnt          <= '0;
         op_q         <= '0;
         halt_req     <= 1'b0;
         halted       <= 1'b0;
         reset_active <= 1'b0;
         jreset_q     <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         op_q         <= op_d;
         halt_req     <= halt_req_d;
         halted       <= halted_d;
         reset_active <= reset_active_d;
         jreset_q     <= jreset_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      op_d           = op_q;
      halt_req_d     = halt_req;
      halted_d       = halted;
      reset_active_d = reset_active;
      jreset_d       = jreset_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      dmi_req_ready  = 1'b0;
      dmi_resp_valid = 1'b0;
      reg_wen        = 1'b0;

      case (state)
         S_IDLE: begin
            dmi_req_ready = 1'b1;
            if (dmi_req_valid) begin
               op_d    = dmi_req_op;
               err_d   = 1'b0;
               rdata_d = status;
               state_d = S_RESP;
               if (dmi_req_op == OP_READ || dmi_req_op == OP_WRITE) begin
                  if (!halted) begin
                     err_d   = 1'b1;
                     rdata_d = '0;
                  end else begin
                     addr_d = dmi_req_addr;
                     if (dmi_req_op == OP_WRITE) wdata_d = dmi_req_data;
                     state_d = S_ACCESS;
                  end
               end else if (dmi_req_op != OP_STATUS) begin
                  // ndmreset wins over halt/resume bits, including the conflict case
                  if (ctrl[2]) begin
                     jreset_d       = 1'b1;
                     reset_active_d = 1'b1;
                     cnt_d          = 4'(RESET_CYCLES);
                     state_d        = S_RST;
                  end else if (ctrl[1:0] == 2'b11) begin
                     err_d = 1'b1;
                  end else if (ctrl[0]) begin
                     halt_req_d = 1'b1;
                     cnt_d      = 4'(HALT_SETTLE);
                     state_d    = S_SETTLE;
                  end else if (ctrl[1]) begin
                     halt_req_d = 1'b0;
                     halted_d   = 1'b0;
                     rdata_d    = {29'b0, reset_active, 2'b00};
                  end
               end
            end
         end
         S_SETTLE: begin
            if (cnt == 4'd1) begin
               halted_d = 1'b1;
               rdata_d  = {29'b0, reset_active, 1'b1, halt_req};
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         S_ACCESS: begin
            reg_wen = (op_q == OP_WRITE) && (addr_q != 5'd0);
            if (op_q == OP_READ) rdata_d = reg_r_data;
            state_d = S_RESP;
         end
         S_RST: begin
            if (cnt == 4'd1) begin
               jreset_d       = 1'b0;
               reset_active_d = 1'b0;
               rdata_d        = {29'b0, 1'b0, halted, halt_req};
               state_d        = S_RESP;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         S_RESP: begin
            dmi_resp_valid = 1'b1;
            if (dmi_resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dmi_resp_data = rdata_q;
   assign dmi_resp_err  = err_q;
   assign jtag_halt     = halt_req;
   assign jtag_reset    = jreset_q;
   assign reg_addr      = addr_q;
   assign reg_w_data    = wdata_q;

endmodule
